// File: rtl/pipe_core_if.sv
// Memory and retirement-trace bundle for pipe_core.
// master = core side, slave = memory/trace consumer side.
interface pipe_core_if #(
  parameter int XLEN = 64,
  parameter int PC_W = 8
);
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic [PC_W-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_we;
  logic            dmem_re;
  logic [XLEN-1:0] dmem_rdata;
  logic            retire_valid;
  logic [PC_W-1:0] retire_pc;
  logic [4:0]      retire_rd;
  logic [XLEN-1:0] retire_data;

  modport master (
    output imem_addr, input imem_data,
    output dmem_addr, dmem_wdata, dmem_we, dmem_re, input dmem_rdata,
    output retire_valid, retire_pc, retire_rd, retire_data
  );

  modport slave (
    input imem_addr, output imem_data,
    input dmem_addr, dmem_wdata, dmem_we, dmem_re, output dmem_rdata,
    input retire_valid, retire_pc, retire_rd, retire_data
  );
endinterface

// File: rtl/pipe_core.sv
// Five-stage RV64I-subset pipeline (IF/ID/EX/MEM/WB) with hazard stall and branch flush.
// Optional macro FORWARDING_EN enables EX/MEM and MEM/WB bypass into EX operands.
module pipe_core #(
  parameter int XLEN = 64,
  parameter int PC_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_core_if.master bus
);

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_e;

  logic [XLEN-1:0] rf [32];
  logic [PC_W-1:0] pc;

  logic            ifid_valid;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;

  logic            idex_valid, idex_we, idex_ld, idex_sd, idex_beq, idex_use_imm;
  alu_op_e         idex_alu;
  logic [PC_W-1:0] idex_pc;
  logic [4:0]      idex_rd;
  logic [XLEN-1:0] idex_a, idex_b, idex_imm;
`ifdef FORWARDING_EN
  logic [4:0]      idex_rs1, idex_rs2;
`endif

  logic            exmem_valid, exmem_we, exmem_ld, exmem_sd;
  logic [PC_W-1:0] exmem_pc;
  logic [4:0]      exmem_rd;
  logic [XLEN-1:0] exmem_alu, exmem_sdata;

  logic            memwb_valid, memwb_we;
  logic [PC_W-1:0] memwb_pc;
  logic [4:0]      memwb_rd;
  logic [XLEN-1:0] memwb_data;

  // Decode
  logic            d_we, d_ld, d_sd, d_beq, d_use_imm;
  alu_op_e         d_alu;
  logic [4:0]      d_rd, d_rs1, d_rs2;
  logic [XLEN-1:0] d_imm, d_a, d_b;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;

  assign opc = ifid_instr[6:0];
  assign f3  = ifid_instr[14:12];
  assign f7  = ifid_instr[31:25];

  always_comb begin
    d_we      = 1'b0;
    d_ld      = 1'b0;
    d_sd      = 1'b0;
    d_beq     = 1'b0;
    d_use_imm = 1'b0;
    d_alu     = ALU_ADD;
    d_rs1     = 5'd0;
    d_rs2     = 5'd0;
    d_imm     = {{(XLEN-12){ifid_instr[31]}}, ifid_instr[31:20]};
    unique case (opc)
      7'b0110011: begin
        if (f3 == 3'b000 && f7 == 7'b0000000) begin
          d_we = 1'b1; d_alu = ALU_ADD;
        end else if (f3 == 3'b000 && f7 == 7'b0100000) begin
          d_we = 1'b1; d_alu = ALU_SUB;
        end else if (f3 == 3'b111 && f7 == 7'b0000000) begin
          d_we = 1'b1; d_alu = ALU_AND;
        end else if (f3 == 3'b110 && f7 == 7'b0000000) begin
          d_we = 1'b1; d_alu = ALU_OR;
        end
        if (d_we) begin
          d_rs1 = ifid_instr[19:15];
          d_rs2 = ifid_instr[24:20];
        end
      end
      7'b0010011: if (f3 == 3'b000) begin
        d_we = 1'b1; d_use_imm = 1'b1; d_rs1 = ifid_instr[19:15];
      end
      7'b0000011: if (f3 == 3'b011) begin
        d_we = 1'b1; d_ld = 1'b1; d_use_imm = 1'b1; d_rs1 = ifid_instr[19:15];
      end
      7'b0100011: if (f3 == 3'b011) begin
        d_sd = 1'b1; d_use_imm = 1'b1;
        d_rs1 = ifid_instr[19:15];
        d_rs2 = ifid_instr[24:20];
        d_imm = {{(XLEN-12){ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
      end
      7'b1100011: if (f3 == 3'b000) begin
        d_beq = 1'b1; d_alu = ALU_SUB;
        d_rs1 = ifid_instr[19:15];
        d_rs2 = ifid_instr[24:20];
        d_imm = {{(XLEN-13){ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                 ifid_instr[30:25], ifid_instr[11:8], 1'b0};
      end
      default: ;
    endcase
    // x0 destinations never write, which also keeps them out of hazard matching
    d_rd = ifid_instr[11:7];
    if (d_rd == 5'd0) d_we = 1'b0;
    if (!d_we) d_rd = 5'd0;
  end

  // Register read with write-through from WB
  always_comb begin
    d_a = rf[d_rs1];
    d_b = rf[d_rs2];
    if (memwb_valid && memwb_we && memwb_rd == d_rs1) d_a = memwb_data;
    if (memwb_valid && memwb_we && memwb_rd == d_rs2) d_b = memwb_data;
    if (d_rs1 == 5'd0) d_a = '0;
    if (d_rs2 == 5'd0) d_b = '0;
  end

  logic stall;
`ifdef FORWARDING_EN
  assign stall = ifid_valid && idex_valid && idex_ld && idex_we &&
                 (idex_rd == d_rs1 || idex_rd == d_rs2);
`else
  assign stall = ifid_valid &&
                 ((idex_valid && idex_we && (idex_rd == d_rs1 || idex_rd == d_rs2)) ||
                  (exmem_valid && exmem_we && (exmem_rd == d_rs1 || exmem_rd == d_rs2)));
`endif

  // Execute
  logic [XLEN-1:0] op_a, op_b, alu_b, alu_res;
  logic            take;
  logic [PC_W-1:0] target;

  always_comb begin
    op_a = idex_a;
    op_b = idex_b;
`ifdef FORWARDING_EN
    // EX/MEM is the younger producer, so it overrides MEM/WB
    if (memwb_valid && memwb_we && memwb_rd == idex_rs1) op_a = memwb_data;
    if (memwb_valid && memwb_we && memwb_rd == idex_rs2) op_b = memwb_data;
    if (exmem_valid && exmem_we && !exmem_ld && exmem_rd == idex_rs1) op_a = exmem_alu;
    if (exmem_valid && exmem_we && !exmem_ld && exmem_rd == idex_rs2) op_b = exmem_alu;
`endif
    alu_b   = idex_use_imm ? idex_imm : op_b;
    alu_res = op_a + alu_b;
    unique case (idex_alu)
      ALU_SUB: alu_res = op_a - alu_b;
      ALU_AND: alu_res = op_a & alu_b;
      ALU_OR:  alu_res = op_a | alu_b;
      default: ;
    endcase
  end

  assign take   = idex_valid && idex_beq && (alu_res == '0);
  assign target = idex_pc + idex_imm[PC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      ifid_valid   <= 1'b0;
      ifid_pc      <= '0;
      ifid_instr   <= '0;
      idex_valid   <= 1'b0;
      idex_we      <= 1'b0;
      idex_ld      <= 1'b0;
      idex_sd      <= 1'b0;
      idex_beq     <= 1'b0;
      idex_use_imm <= 1'b0;
      idex_alu     <= ALU_ADD;
      idex_pc      <= '0;
      idex_rd      <= '0;
      idex_a       <= '0;
      idex_b       <= '0;
      idex_imm     <= '0;
`ifdef FORWARDING_EN
      idex_rs1     <= '0;
      idex_rs2     <= '0;
`endif
      exmem_valid  <= 1'b0;
      exmem_we     <= 1'b0;
      exmem_ld     <= 1'b0;
      exmem_sd     <= 1'b0;
      exmem_pc     <= '0;
      exmem_rd     <= '0;
      exmem_alu    <= '0;
      exmem_sdata  <= '0;
      memwb_valid  <= 1'b0;
      memwb_we     <= 1'b0;
      memwb_pc     <= '0;
      memwb_rd     <= '0;
      memwb_data   <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      // Taken branch wins over a simultaneous stall
      if (take) begin
        pc         <= target;
        ifid_valid <= 1'b0;
        ifid_instr <= '0;
      end else if (!stall) begin
        pc         <= pc + PC_W'(4);
        ifid_valid <= 1'b1;
        ifid_pc    <= pc;
        ifid_instr <= bus.imem_data;
      end

      idex_valid   <= ifid_valid && !take && !stall;
      idex_we      <= d_we;
      idex_ld      <= d_ld;
      idex_sd      <= d_sd;
      idex_beq     <= d_beq;
      idex_use_imm <= d_use_imm;
      idex_alu     <= d_alu;
      idex_pc      <= ifid_pc;
      idex_rd      <= d_rd;
      idex_a       <= d_a;
      idex_b       <= d_b;
      idex_imm     <= d_imm;
`ifdef FORWARDING_EN
      idex_rs1     <= d_rs1;
      idex_rs2     <= d_rs2;
`endif

      exmem_valid <= idex_valid;
      exmem_we    <= idex_we;
      exmem_ld    <= idex_ld;
      exmem_sd    <= idex_sd;
      exmem_pc    <= idex_pc;
      exmem_rd    <= idex_rd;
      exmem_alu   <= alu_res;
      exmem_sdata <= op_b;

      memwb_valid <= exmem_valid;
      memwb_we    <= exmem_we;
      memwb_pc    <= exmem_pc;
      memwb_rd    <= exmem_rd;
      memwb_data  <= exmem_ld ? bus.dmem_rdata : exmem_alu;

      if (memwb_valid && memwb_we && memwb_rd != 5'd0) rf[memwb_rd] <= memwb_data;
    end
  end

  assign bus.imem_addr    = pc;
  assign bus.dmem_addr    = exmem_alu[PC_W-1:0];
  assign bus.dmem_wdata   = exmem_sdata;
  assign bus.dmem_we      = exmem_valid && exmem_sd;
  assign bus.dmem_re      = exmem_valid && exmem_ld;
  assign bus.retire_valid = memwb_valid;
  assign bus.retire_pc    = memwb_valid ? memwb_pc : '0;
  assign bus.retire_rd    = (memwb_valid && memwb_we) ? memwb_rd : 5'd0;
  assign bus.retire_data  = (memwb_valid && memwb_we) ? memwb_data : '0;

endmodule
